// File: rtl/ula_op_driver_if.sv
// ============================================================================
// ula_op_driver_if : command, ULA and response bundle around the op driver
// Rev 1.0
// ============================================================================
`default_nettype none

interface ula_op_driver_if #(
  parameter int CNT_W = 16
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic [7:0]       ula_a;
  logic [7:0]       ula_b;
  logic [2:0]       ula_opcode;
  logic [8:0]       ula_s;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [8:0]       rsp_s;
  logic [2:0]       rsp_op;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, ula_s, rsp_ready,
    output cmd_ready, ula_a, ula_b, ula_opcode, rsp_valid, rsp_s, rsp_op,
           busy, op_count
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, ula_s, rsp_ready,
    input  cmd_ready, ula_a, ula_b, ula_opcode, rsp_valid, rsp_s, rsp_op,
           busy, op_count
  );
endinterface

`default_nettype wire

// File: rtl/ula_op_driver.sv
// ============================================================================
// ula_op_driver : issues one ALU command to the ULA, waits its latency and
//                 returns the captured 9-bit result over a valid/ready port
// Rev 1.0
// ============================================================================
`default_nettype none

module ula_op_driver #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  ula_op_driver_if.master  bus_io
);

  localparam int WCNT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [WCNT_W-1:0] C_LAT = WCNT_W'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic [7:0]         ula_a_q, ula_a_d;
  logic [7:0]         ula_b_q, ula_b_d;
  logic [2:0]         ula_opcode_q, ula_opcode_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [8:0]         rsp_s_q, rsp_s_d;
  logic [2:0]         rsp_op_q, rsp_op_d;
  logic [CNT_W-1:0]   op_count_q, op_count_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wcnt_q       <= '0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      ula_a_q      <= '0;
      ula_b_q      <= '0;
      ula_opcode_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_s_q      <= '0;
      rsp_op_q     <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      ula_a_q      <= ula_a_d;
      ula_b_q      <= ula_b_d;
      ula_opcode_q <= ula_opcode_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_s_q      <= rsp_s_d;
      rsp_op_q     <= rsp_op_d;
      op_count_q   <= op_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    ula_a_d      = ula_a_q;
    ula_b_d      = ula_b_q;
    ula_opcode_d = ula_opcode_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_s_d      = rsp_s_q;
    rsp_op_d     = rsp_op_q;
    op_count_d   = op_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus_io.cmd_valid && cmd_ready_q) begin
          ula_a_d      = bus_io.cmd_a;
          ula_b_d      = bus_io.cmd_b;
          ula_opcode_d = bus_io.cmd_op;
          wcnt_d       = C_LAT;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // Counter reaching zero marks the edge at which ula_s reflects the new inputs.
        if (wcnt_q == '0) begin
          rsp_s_d     = bus_io.ula_s;
          rsp_op_d    = ula_opcode_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_valid_q && bus_io.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  assign bus_io.cmd_ready  = cmd_ready_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.ula_a      = ula_a_q;
  assign bus_io.ula_b      = ula_b_q;
  assign bus_io.ula_opcode = ula_opcode_q;
  assign bus_io.rsp_valid  = rsp_valid_q;
  assign bus_io.rsp_s      = rsp_s_q;
  assign bus_io.rsp_op     = rsp_op_q;
  assign bus_io.op_count   = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ula_op_driver.sv
// ============================================================================
// tb_ula_op_driver : self-checking bench for ula_op_driver with a registered
//                    ULA model and a transaction-level reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ula_op_driver;

  localparam int LATENCY = 1;
  localparam int CNT_W   = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_count = 0;

  ula_op_driver_if #(.CNT_W(CNT_W)) bus ();

  ula_op_driver #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] ula_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {1'b0, b};
    endcase
  endfunction

  // Registered ULA: result appears one edge after its inputs change.
  always @(posedge clk) bus.ula_s <= ula_fn(bus.ula_a, bus.ula_b, bus.ula_opcode);

  function automatic logic [CNT_W-1:0] exp_cnt();
    return CNT_W'(exp_count % (1 << CNT_W));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd_ready(input string tag);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_cmd_ready_timeout: cmd_ready=%b after %0d cycles, required 1", tag, bus.cmd_ready, n);
    end
  endtask

  task automatic wait_rsp_valid(input string tag, output int n);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (n != LATENCY + 1) begin
      miscompares++;
      $display("FAIL %s_latency: rsp_valid after %0d cycles, required %0d", tag, n, LATENCY + 1);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int stall, input string tag);
    int n;
    logic [8:0] exp_s;
    exp_s = ula_fn(a, b, op);
    wait_cmd_ready(tag);
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    vectors++;
    if (bus.ula_a !== a || bus.ula_b !== b || bus.ula_opcode !== op ||
        bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_issue: ula_a=%h ula_b=%h ula_op=%h cmd_ready=%b busy=%b, required %h %h %h 0 1",
               tag, bus.ula_a, bus.ula_b, bus.ula_opcode, bus.cmd_ready, bus.busy, a, b, op);
    end
    wait_rsp_valid(tag, n);
    for (int i = 0; i <= stall; i++) begin
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_s !== exp_s || bus.rsp_op !== op) begin
        miscompares++;
        $display("FAIL %s_result: rsp_valid=%b rsp_s=%h rsp_op=%h, required 1 %h %h",
                 tag, bus.rsp_valid, bus.rsp_s, bus.rsp_op, exp_s, op);
      end
      if (i < stall) tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count++;
    vectors++;
    if (bus.rsp_valid !== 1'b0 || bus.op_count !== exp_cnt() ||
        bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_complete: rsp_valid=%b op_count=%0d cmd_ready=%b busy=%b, required 0 %0d 1 0",
               tag, bus.rsp_valid, bus.op_count, bus.cmd_ready, bus.busy, exp_cnt());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_a = 8'hA5; bus.cmd_b = 8'h3C; bus.cmd_op = 3'd4;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          bus.rsp_s !== 9'd0 || bus.rsp_op !== 3'd0 || bus.op_count !== '0 ||
          bus.ula_a !== 8'd0 || bus.ula_b !== 8'd0 || bus.ula_opcode !== 3'd0) begin
        miscompares++;
        $display("FAIL reset_outputs: cmd_ready=%b busy=%b rsp_valid=%b rsp_s=%h rsp_op=%h op_count=%h ula=%h/%h/%h, required all 0",
                 bus.cmd_ready, bus.busy, bus.rsp_valid, bus.rsp_s, bus.rsp_op, bus.op_count,
                 bus.ula_a, bus.ula_b, bus.ula_opcode);
      end
    end
    rst_n = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    exp_count = 0;
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.ula_a !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b ula_a=%h, required 1 0 00",
               bus.cmd_ready, bus.busy, bus.ula_a);
    end
  endtask

  task automatic test_directed();
    run_op(8'h01, 8'h01, 3'd0, 0, "add_1_1");
    vectors++;
    if (bus.ula_a !== 8'h01 || bus.ula_opcode !== 3'd0) begin
      miscompares++;
      $display("FAIL ula_hold: ula_a=%h ula_op=%h, required 01 0", bus.ula_a, bus.ula_opcode);
    end
    run_op(8'hFF, 8'h01, 3'd0, 0, "add_carry");
  endtask

  task automatic test_stall();
    logic [7:0] a1, b1, a2, b2;
    logic [2:0] op1, op2;
    logic [8:0] s1;
    int n;
    a1 = 8'($urandom); b1 = 8'($urandom); op1 = 3'($urandom);
    a2 = a1 ^ 8'h5A;   b2 = 8'($urandom); op2 = op1 + 3'd3;
    s1 = ula_fn(a1, b1, op1);
    wait_cmd_ready("stall");
    bus.cmd_a = a1; bus.cmd_b = b1; bus.cmd_op = op1; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    wait_rsp_valid("stall", n);
    bus.cmd_a = a2; bus.cmd_b = b2; bus.cmd_op = op2; bus.cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_s !== s1 || bus.rsp_op !== op1 ||
          bus.cmd_ready !== 1'b0 || bus.ula_a !== a1) begin
        miscompares++;
        $display("FAIL stall_hold: rsp_valid=%b rsp_s=%h rsp_op=%h cmd_ready=%b ula_a=%h, required 1 %h %h 0 %h",
                 bus.rsp_valid, bus.rsp_s, bus.rsp_op, bus.cmd_ready, bus.ula_a, s1, op1, a1);
      end
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count++;
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.op_count !== exp_cnt() || bus.ula_a !== a1) begin
      miscompares++;
      $display("FAIL stall_release: cmd_ready=%b op_count=%0d ula_a=%h, required 1 %0d %h",
               bus.cmd_ready, bus.op_count, bus.ula_a, exp_cnt(), a1);
    end
    tick();
    bus.cmd_valid = 1'b0;
    vectors++;
    if (bus.ula_a !== a2 || bus.ula_b !== b2 || bus.ula_opcode !== op2) begin
      miscompares++;
      $display("FAIL stall_second_cmd: ula=%h/%h/%h, required %h/%h/%h",
               bus.ula_a, bus.ula_b, bus.ula_opcode, a2, b2, op2);
    end
    wait_rsp_valid("stall2", n);
    vectors++;
    if (bus.rsp_s !== ula_fn(a2, b2, op2) || bus.rsp_op !== op2) begin
      miscompares++;
      $display("FAIL stall_second_result: rsp_s=%h rsp_op=%h, required %h %h",
               bus.rsp_s, bus.rsp_op, ula_fn(a2, b2, op2), op2);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_count++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_op(8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(0, 3)), "random");
  endtask

  task automatic test_reset_wait();
    wait_cmd_ready("abort");
    bus.cmd_a = 8'h77; bus.cmd_b = 8'h11; bus.cmd_op = 3'd1; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    exp_count = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.op_count !== exp_cnt() ||
          bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_wait: rsp_valid=%b op_count=%0d cmd_ready=%b busy=%b, required 0 0 1 0",
                 bus.rsp_valid, bus.op_count, bus.cmd_ready, bus.busy);
      end
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc, prev_acc, rsp_cyc, n;
    logic [7:0] a, b;
    prev_acc = -1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_cmd_ready("b2b");
      a = 8'($urandom); b = 8'($urandom);
      bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = 3'(i); bus.cmd_valid = 1'b1;
      tick();
      acc = cyc;
      wait_rsp_valid("b2b", n);
      rsp_cyc = cyc;
      vectors++;
      if (bus.rsp_op !== 3'(i) || bus.rsp_s !== ula_fn(a, b, 3'(i)) || rsp_cyc - acc != LATENCY + 1) begin
        miscompares++;
        $display("FAIL b2b_resp%0d: rsp_op=%h rsp_s=%h delay=%0d, required %h %h %0d",
                 i, bus.rsp_op, bus.rsp_s, rsp_cyc - acc, 3'(i), ula_fn(a, b, 3'(i)), LATENCY + 1);
      end
      if (prev_acc >= 0) begin
        vectors++;
        if (acc - prev_acc != LATENCY + 3) begin
          miscompares++;
          $display("FAIL b2b_spacing%0d: %0d cycles, required %0d", i, acc - prev_acc, LATENCY + 3);
        end
      end
      prev_acc = acc;
      tick();
      exp_count++;
      vectors++;
      if (bus.rsp_valid !== 1'b0 || bus.op_count !== exp_cnt()) begin
        miscompares++;
        $display("FAIL b2b_count%0d: rsp_valid=%b op_count=%0d, required 0 %0d",
                 i, bus.rsp_valid, bus.op_count, exp_cnt());
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
